// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
// fm_pkg : shared FSM encodings and window-length helper for fm_zc_demod
// Revision 1.0
// ============================================================================
package fm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_COUNT = 2'd2
    } fm_state_t;

    function automatic int unsigned fm_win_len(input int unsigned gate_log2);
        return 32'd1 << gate_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fm_zc_demod_if.sv
`default_nettype none
// ============================================================================
// fm_zc_demod_if : sample-side strobe/data and estimate outputs of fm_zc_demod
// Revision 1.0
// ============================================================================
interface fm_zc_demod_if #(
    parameter int NBITS        = 13,
    parameter int N_INPUT_BITS = 9
);
    logic                           enableclk;
    logic                           run;
    logic signed [N_INPUT_BITS-1:0] insample;
    logic        [NBITS-1:0]        phaseinc_est;
    logic                           est_valid;

    modport master (
        output enableclk, run, insample,
        input  phaseinc_est, est_valid
    );

    modport slave (
        input  enableclk, run, insample,
        output phaseinc_est, est_valid
    );
endinterface
`default_nettype wire

// File: rtl/fm_zc_detect.sv
`default_nettype none
// ============================================================================
// fm_zc_detect : sample sign register and rising zero-crossing pulse
// Schmitt-trigger sign when FMDEMOD_HYST_EN is defined.  Revision 1.0
// ============================================================================
module fm_zc_detect #(
    parameter int N_INPUT_BITS = 9,
    parameter int HYST         = 8
) (
    input  wire logic                           clock,
    input  wire logic                           reset,
    input  wire logic                           sample_en,
    input  wire logic                           prime,
    input  wire logic                           count_en,
    input  wire logic signed [N_INPUT_BITS-1:0] insample,
    output logic                                rise
);
    logic r_neg;
    logic w_next_neg;

`ifdef FMDEMOD_HYST_EN
    localparam logic signed [N_INPUT_BITS-1:0] c_hyst_hi = N_INPUT_BITS'(HYST);
    localparam logic signed [N_INPUT_BITS-1:0] c_hyst_lo = N_INPUT_BITS'(-HYST);

    logic w_below;
    logic w_above;

    assign w_below = (insample <= c_hyst_lo);
    assign w_above = (insample >= c_hyst_hi);

    // A dead-band sample keeps the old sign, except when priming where
    // there is no meaningful history and positive is assumed.
    always_comb begin
        w_next_neg = r_neg;
        if (w_below) begin
            w_next_neg = 1'b1;
        end else if (w_above || prime) begin
            w_next_neg = 1'b0;
        end
    end
`else
    logic w_unused_detect;

    assign w_next_neg      = insample[N_INPUT_BITS-1];
    assign w_unused_detect = ^{prime, insample[N_INPUT_BITS-2:0], (HYST > 0)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_neg <= 1'b0;
        end else if (sample_en) begin
            r_neg <= w_next_neg;
        end
    end

    assign rise = count_en & r_neg & ~w_next_neg;

endmodule
`default_nettype wire

// File: rtl/fm_zc_demod.sv
`default_nettype none
// ============================================================================
// fm_zc_demod : zero-crossing FM demodulator, phase-increment estimate per gate
// Optional macro FMDEMOD_HYST_EN enables hysteresis.  Revision 1.0
// ============================================================================
module fm_zc_demod
    import fm_pkg::*;
#(
    parameter int NBITS        = 13,
    parameter int N_INPUT_BITS = 9,
    parameter int GATE_LOG2    = 10,
    parameter int HYST         = 8
) (
    input  wire logic    clock,
    input  wire logic    reset,
    fm_zc_demod_if.slave bus
);
    localparam int                   c_shift    = NBITS - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] c_win_last = GATE_LOG2'(fm_win_len(GATE_LOG2) - 1);

    fm_state_t r_state;
    fm_state_t w_state_next;

    logic                 w_sample_en;
    logic                 w_prime;
    logic                 w_count;
    logic                 w_rise;
    logic [GATE_LOG2-1:0] r_win;
    logic [GATE_LOG2-1:0] r_cnt;
    logic [GATE_LOG2-1:0] w_total;
    logic [NBITS-1:0]     r_est;
    logic                 r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample_en  = 1'b0;
        w_prime      = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                if (bus.enableclk) begin
                    w_sample_en  = 1'b1;
                    w_prime      = 1'b1;
                    w_state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (bus.enableclk) begin
                    w_sample_en = 1'b1;
                    w_count     = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Dropping run overrides everything: the clock is not a sample.
        if (!bus.run) begin
            w_state_next = ST_IDLE;
            w_sample_en  = 1'b0;
            w_prime      = 1'b0;
            w_count      = 1'b0;
        end
    end

    fm_zc_detect #(
        .N_INPUT_BITS (N_INPUT_BITS),
        .HYST         (HYST)
    ) u_detect (
        .clock     (clock),
        .reset     (reset),
        .sample_en (w_sample_en),
        .prime     (w_prime),
        .count_en  (w_count),
        .insample  (bus.insample),
        .rise      (w_rise)
    );

    assign w_total = r_cnt + GATE_LOG2'(w_rise);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win   <= '0;
            r_cnt   <= '0;
            r_est   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.run || r_state == ST_IDLE) begin
                r_win <= '0;
                r_cnt <= '0;
            end else if (w_count) begin
                r_win <= r_win + 1'b1;
                // Closing sample: its own crossing is part of this window's total.
                if (r_win == c_win_last) begin
                    r_cnt   <= '0;
                    r_est   <= NBITS'(w_total) << c_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_cnt <= w_total;
                end
            end
        end
    end

    assign bus.phaseinc_est = r_est;
    assign bus.est_valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fm_zc_demod.sv
`default_nettype none
// ============================================================================
// tb_fm_zc_demod : self-checking bench for fm_zc_demod against a window model
// Revision 1.0
// ============================================================================
module tb_fm_zc_demod;
    localparam int NBITS = 13;
    localparam int NIN   = 9;
    localparam int GL2   = 10;
    localparam int HYST  = 8;
    localparam int WIN   = 1024;
    localparam int SCALE = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fm_zc_demod_if #(.NBITS(NBITS), .N_INPUT_BITS(NIN)) bus ();

    fm_zc_demod #(
        .NBITS(NBITS), .N_INPUT_BITS(NIN), .GATE_LOG2(GL2), .HYST(HYST)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = idle, 1 = waiting for priming sample, 2 = measuring.
    int               m_mode;
    bit               m_neg;
    int               m_n;
    int               m_cnt;
    logic [NBITS-1:0] exp_est;
    logic             exp_valid;
    int               cyc = 0;

    function automatic bit ref_neg(input int s, input bit prev, input bit first);
`ifdef FMDEMOD_HYST_EN
        if (s <= -HYST) return 1'b1;
        if (s >= HYST)  return 1'b0;
        return first ? 1'b0 : prev;
`else
        if (first && prev) return s < 0;
        return s < 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_neg = 1'b0; m_n = 0; m_cnt = 0;
        exp_est = '0; exp_valid = 1'b0;
    endtask

    task automatic step(input bit en, input bit rn, input int s);
        bit nn;
        bus.enableclk = en;
        bus.run       = rn;
        bus.insample  = NIN'(s);
        @(posedge clk);
        cyc++;
        exp_valid = 1'b0;
        if (!rn) begin
            m_mode = 0; m_n = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (en) begin
            if (m_mode == 1) begin
                m_neg  = ref_neg(s, m_neg, 1'b1);
                m_mode = 2;
            end else begin
                nn = ref_neg(s, m_neg, 1'b0);
                if (m_neg && !nn) m_cnt++;
                m_neg = nn;
                m_n++;
                if (m_n == WIN) begin
                    exp_est   = NBITS'(m_cnt * SCALE);
                    exp_valid = 1'b1;
                    m_n = 0; m_cnt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            bus.enableclk = 1'($urandom);
            bus.run       = 1'($urandom);
            bus.insample  = NIN'($urandom);
            @(negedge clk);
            total++;
            if (bus.phaseinc_est !== '0) begin
                bad++; $display("FAIL reset_est got=%0d exp=0", bus.phaseinc_est);
            end
            total++;
            if (bus.est_valid !== 1'b0) begin
                bad++; $display("FAIL reset_valid got=%b exp=0", bus.est_valid);
            end
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 1'b0, $urandom_range(0, 511) - 256);
            total++;
            if (bus.est_valid !== 1'b0) begin
                bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, bus.est_valid);
            end
        end
    endtask

    task automatic test_square();
        int nv = 0;
        for (int i = 0; i < 3 * (WIN + 1) + 8; i++) begin
            step(1'b1, 1'b1, ((i / 16) % 2) ? 100 : -100);
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL sq_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            total++;
            if (bus.phaseinc_est !== exp_est) begin
                bad++; $display("FAIL sq_est cyc=%0d got=%0d exp=%0d", cyc, bus.phaseinc_est, exp_est);
            end
            if (bus.est_valid === 1'b1) begin
                nv++;
                total++;
                if (bus.phaseinc_est !== 13'd256) begin
                    bad++; $display("FAIL sq_const got=%0d exp=256", bus.phaseinc_est);
                end
            end
        end
        total++;
        if (nv != 3) begin
            bad++; $display("FAIL sq_windows got=%0d exp=3", nv);
        end
    endtask

    task automatic test_alt_slow();
        int k = 0;
        int t_first = -1;
        int t_second = -1;
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 2 * 3 * WIN + 40; i++) begin
            step(i % 3 == 0, 1'b1, (k % 2) ? 100 : -100);
            if (i % 3 == 0) k++;
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL alt_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            if (bus.est_valid === 1'b1) begin
                if (t_first < 0) t_first = cyc; else if (t_second < 0) t_second = cyc;
                total++;
                if (bus.phaseinc_est !== 13'd4096) begin
                    bad++; $display("FAIL alt_est got=%0d exp=4096", bus.phaseinc_est);
                end
            end
        end
        total++;
        if (t_second - t_first != 3 * WIN) begin
            bad++; $display("FAIL alt_spacing got=%0d exp=%0d", t_second - t_first, 3 * WIN);
        end
    endtask

    task automatic test_const();
        int nv = 0;
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 2 * WIN + 10; i++) begin
            step(1'b1, 1'b1, 50);
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL const_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            if (bus.est_valid === 1'b1) begin
                nv++;
                total++;
                if (bus.phaseinc_est !== '0) begin
                    bad++; $display("FAIL const_est got=%0d exp=0", bus.phaseinc_est);
                end
            end
        end
        total++;
        if (nv != 2) begin
            bad++; $display("FAIL const_windows got=%0d exp=2", nv);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        bit seen = 1'b0;
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < WIN + 2 + 500; i++) begin
            step(1'b1, 1'b1, ((i / 16) % 2) ? 100 : -100);
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL abort_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 100);
            total++;
            if (bus.est_valid !== 1'b0 || bus.phaseinc_est !== 13'd256) begin
                bad++; $display("FAIL abort_hold got=%b/%0d exp=0/256", bus.est_valid, bus.phaseinc_est);
            end
        end
        // First clock with run high is the idle clock; samples are counted after it.
        step(1'b1, 1'b1, -100);
        while (!seen && n < 3000) begin
            step(1'b1, 1'b1, ((n / 16) % 2) ? -100 : 100);
            n++;
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL restart_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            if (bus.est_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (n != WIN + 1) begin
            bad++; $display("FAIL restart_latency got=%0d exp=%0d", n, WIN + 1);
        end
    endtask

    task automatic test_hyst_noise();
        logic [NBITS-1:0] want;
`ifdef FMDEMOD_HYST_EN
        want = '0;
`else
        want = 13'd4096;
`endif
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < WIN + 3; i++) begin
            step(1'b1, 1'b1, (i % 2) ? 4 : -4);
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL noise_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            if (bus.est_valid === 1'b1) begin
                total++;
                if (bus.phaseinc_est !== want) begin
                    bad++; $display("FAIL noise_est got=%0d exp=%0d", bus.phaseinc_est, want);
                end
            end
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 4 * WIN + 200; i++) begin
            step(1'($urandom), 1'b1, $urandom_range(0, 511) - 256);
            total++;
            if (bus.est_valid !== exp_valid) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
            end
            total++;
            if (bus.phaseinc_est !== exp_est) begin
                bad++; $display("FAIL rnd_est cyc=%0d got=%0d exp=%0d", cyc, bus.phaseinc_est, exp_est);
            end
        end
    endtask

    task automatic test_dds_loopback();
        int acc = 0;
        int nv = 0;
        real pi = 3.14159265358979;
        step(1'b0, 1'b0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < WIN + 2 + 300; i++) begin
                step(1'b1, 1'b1, $rtoi(200.0 * $sin(2.0 * pi * acc / 8192.0)));
                acc = (acc + 256) % 8192;
                total++;
                if (bus.est_valid !== exp_valid) begin
                    bad++; $display("FAIL dds_valid cyc=%0d got=%b exp=%b", cyc, bus.est_valid, exp_valid);
                end
                if (bus.est_valid === 1'b1) begin
                    nv++;
                    total++;
                    if (bus.phaseinc_est < 13'd248 || bus.phaseinc_est > 13'd264) begin
                        bad++; $display("FAIL dds_est got=%0d exp=248..264", bus.phaseinc_est);
                    end
                end
            end
            if (pass == 0) begin
                @(posedge clk); #2 rst_n = 1'b0;
                #1;
                total++;
                if (bus.phaseinc_est !== '0 || bus.est_valid !== 1'b0) begin
                    bad++; $display("FAIL async_reset got=%0d/%b exp=0/0", bus.phaseinc_est, bus.est_valid);
                end
                model_reset();
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        total++;
        if (nv != 2) begin
            bad++; $display("FAIL dds_windows got=%0d exp=2", nv);
        end
    endtask

    initial begin
        bus.enableclk = 1'b0;
        bus.run       = 1'b0;
        bus.insample  = '0;
        model_reset();
        test_reset();
        test_square();
        test_alt_slow();
        test_const();
        test_abort();
        test_hyst_noise();
        test_random();
        test_dds_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
